switch_box_cfg_loader: RTL and testbench
========================================

// Module: switch_box_cfg_loader
// PURPOSE
// Loads configuration words for a row of NUM_SB switch_box_element_two instances
// (12-bit c each) and drives their c buses. Words stream in over valid/ready
// into shadow registers. All boxes are updated atomically in a single commit.
// Tri-state drivers around the boxes are held off (drive_en=0) for GUARD cycles
// before and after the commit, so no partial or transient routing causes bus contention.
// PARAMETERS
// NUM_SB  4   number of switch boxes served (>=1)
// CFG_W   12  config bits per box (matches c width)
// GUARD   2   drive-disable cycles before and after commit (>=1)
// PORTS
// clk       in   1             rising-edge clock
// rst_n     in   1             async active-low reset
// start     in   1             begin a load; sampled only in IDLE
// abort     in   1             cancel a load; honoured only in LOAD
// in_data   in   CFG_W         config word; first word accepted -> box 0
// in_valid  in   1             in_data valid
// in_ready  out  1             1 only in LOAD
// cfg_out   out  NUM_SB*CFG_W  active config; box i = cfg_out[i*CFG_W +: CFG_W]
// drive_en  out  1             permission for external tri-state drivers
// busy      out  1             state != IDLE
// done      out  1             one-cycle pulse: commit complete, drivers re-enabled
// BEHAVIOUR
// Reset (async, rst_n=0):
// - state=IDLE; cfg_out=0 (all switches open); shadow=0; word_idx=0.
// - configured=0; drive_en=0; done=0.
// States: IDLE -> LOAD -> DRAIN -> COMMIT -> RESUME -> IDLE.
// - IDLE: start=1 -> LOAD next cycle, word_idx<=0. start is ignored in all other states.
// - LOAD: in_ready=1. On in_valid&&in_ready: shadow[word_idx]<=in_data, word_idx++.
//   Acceptance of word NUM_SB-1 -> DRAIN. in_valid=0 stalls indefinitely, no timeout.
// - LOAD + abort=1 -> IDLE next cycle. Abort wins over a same-cycle transfer:
//   word not written, shadow contents discarded, cfg_out and configured unchanged, done=0.
// - DRAIN: hold GUARD cycles (guard counter), then COMMIT.
// - COMMIT: one cycle. cfg_out<=shadow (new value visible the cycle after COMMIT);
//   configured<=1.
// - RESUME: hold GUARD cycles, then IDLE with done=1 for exactly that first IDLE cycle.
// - abort and start are ignored in DRAIN, COMMIT and RESUME (commit is atomic).
// Outputs:
// - drive_en = configured && state not in {DRAIN,COMMIT,RESUME}.
//   Implemented as a decode of registered state and flag, or as a register; glitch-free.
// - cfg_out changes only on the COMMIT edge, never otherwise. No per-box partial updates.
// Latency (GUARD=2), last word accepted in cycle t:
// - t+1, t+2 DRAIN; t+3 COMMIT; new cfg_out visible from t+4.
// - t+4, t+5 RESUME; t+6 IDLE with done=1 and drive_en=1.
// - in_ready=0 from t+1 onward.
// Widths:
// - word_idx is $clog2(NUM_SB) bits; NUM_SB=1 uses a 1-bit index.
// - The guard counter is $clog2(GUARD+1) bits. Neither counter wraps within a load.
// Mid-operation reset: returns to reset values immediately, including cfg_out=0
// and drive_en=0. The next load starts with an empty shadow.
// TESTING
// Use NUM_SB=4, CFG_W=12, GUARD=2. Check all outputs on every cycle.
// 1 Reset: rst_n=0 -> cfg_out=0, drive_en=0, busy=0, in_ready=0, done=0.
//   Release, idle 5 cycles -> no change.
// 2 start, then 12'h001,12'h0F0,12'hA5A,12'hFFF with in_valid continuous
//   -> cfg_out=48'hFFF_A5A_0F0_001 visible 4 cycles after the last accept,
//      done=1 and drive_en=1 6 cycles after the last accept.
// 3 Same load, in_valid dropped 3 cycles between each word
//   -> identical final cfg_out; in_ready stays 1 throughout LOAD.
// 4 From scenario 2 state: start, accept 2 words, abort=1 with in_valid=1
//   -> IDLE next cycle, cfg_out still 48'hFFF_A5A_0F0_001, drive_en=1, done=0.
// 5 start and abort asserted repeatedly during DRAIN, COMMIT and RESUME
//   -> no effect: commit completes, single done pulse.
//   drive_en=0 in all 2+1+2 guard/commit cycles.
// 6 rst_n=0 pulsed in COMMIT cycle -> cfg_out=0, drive_en=0 asynchronously.
//   A fresh load then completes normally.

Source files
------------

// File: rtl/switch_box_cfg_loader.sv
// Streams per-box configuration words into a shadow bank and commits them to all
// switch boxes at once, with tri-state drive disabled for GUARD cycles around the commit.
module switch_box_cfg_loader #(
  parameter int NUM_SB = 4,
  parameter int CFG_W  = 12,
  parameter int GUARD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CFG_W-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_SB*CFG_W-1:0]  cfg_out,
  output logic                     drive_en,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (NUM_SB > 1) ? $clog2(NUM_SB) : 1;
  localparam int GRD_W = $clog2(GUARD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SB - 1);
  localparam logic [GRD_W-1:0] LAST_GRD = GRD_W'(GUARD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, COMMIT, RESUME} state_t;

  state_t                         state, state_next;
  logic [IDX_W-1:0]               word_idx;
  logic [GRD_W-1:0]               guard_cnt;
  logic [NUM_SB-1:0][CFG_W-1:0]   shadow;
  logic                           configured;
  logic                           accept;
  logic                           guard_last;

  always_comb begin
    state_next = state;
    accept     = (state == LOAD) && in_valid && !abort;
    guard_last = (guard_cnt == LAST_GRD);
    in_ready   = (state == LOAD);
    busy       = (state != IDLE);
    // Drivers stay off for the whole guard/commit window, decoded from registered state.
    drive_en   = configured && !((state == DRAIN) || (state == COMMIT) || (state == RESUME));
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD: begin
        if (abort)                                   state_next = IDLE;
        else if (in_valid && (word_idx == LAST_IDX)) state_next = DRAIN;
      end
      DRAIN:   if (guard_last) state_next = COMMIT;
      COMMIT:  state_next = RESUME;
      RESUME:  if (guard_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_idx   <= '0;
      guard_cnt  <= '0;
      configured <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == RESUME) && guard_last;
      if (state != state_next)
        guard_cnt <= '0;
      else if ((state == DRAIN) || (state == RESUME))
        guard_cnt <= guard_cnt + GRD_W'(1);
      if ((state == IDLE) && start)
        word_idx <= '0;
      else if (accept && (word_idx != LAST_IDX))
        word_idx <= word_idx + IDX_W'(1);
      if (state == COMMIT)
        configured <= 1'b1;
    end
  end

  // Shadow bank and the live configuration; cfg_out moves only on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      cfg_out <= '0;
    end else begin
      if (accept)
        shadow[word_idx] <= in_data;
      else if ((state == LOAD) && abort)
        shadow <= '0;
      if (state == COMMIT)
        cfg_out <= shadow;
    end
  end

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Directed cycle-by-cycle bench for switch_box_cfg_loader with a commit scoreboard.
module tb_switch_box_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] cfg_out;
  logic        drive_en;
  logic        busy;
  logic        done;

  int          total;
  int          passed;
  logic [47:0] sb[$];
  logic [47:0] cfg_exp;
  logic        de_exp;

  switch_box_cfg_loader #(.NUM_SB(4), .CFG_W(12), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_out(cfg_out), .drive_en(drive_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outs(input logic [47:0] ecfg, input logic ede, input logic eb,
                            input logic er, input logic ed);
    check("cfg_out", cfg_out, ecfg);
    check("drive_en", 48'(drive_en), 48'(ede));
    check("busy", 48'(busy), 48'(eb));
    check("in_ready", 48'(in_ready), 48'(er));
    check("done", 48'(done), 48'(ed));
  endtask

  // One clock cycle: sample on the falling edge, then pop the scoreboard on done.
  task automatic cyc(input logic [47:0] ecfg, input logic ede, input logic eb,
                     input logic er, input logic ed);
    logic [47:0] e;
    @(negedge clk);
    check_outs(ecfg, ede, eb, er, ed);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $error("FAIL sb_unexpected_done observed=done expected=no_pending_commit");
      end else begin
        e = sb.pop_front();
        check("sb_cfg", cfg_out, e);
      end
    end
  endtask

  task automatic do_load(input logic [47:0] words, input int gap, input logic noisy,
                         input logic rst_in_commit);
    cyc(cfg_exp, de_exp, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        cyc(cfg_exp, de_exp, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 12'hBAD;
      end
      cyc(cfg_exp, de_exp, 1'b1, 1'b1, 1'b0);
      start = 1'b0;
      in_valid = 1'b1;
      in_data = words[i*12 +: 12];
    end
    sb.push_back(words);
    for (int k = 0; k < 2; k++) begin
      cyc(cfg_exp, 1'b0, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b0;
      start = noisy;
      abort = noisy;
    end
    cyc(cfg_exp, 1'b0, 1'b1, 1'b0, 1'b0);
    if (rst_in_commit) begin
      #2 rst_n = 1'b0;
      #1 check_outs(48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_back());
      start = 1'b0;
      abort = 1'b0;
      cfg_exp = 48'h0;
      de_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    start = noisy;
    abort = noisy;
    cfg_exp = words;
    for (int k = 0; k < 2; k++) begin
      cyc(cfg_exp, 1'b0, 1'b1, 1'b0, 1'b0);
      start = noisy;
      abort = noisy;
    end
    de_exp = 1'b1;
    cyc(cfg_exp, 1'b1, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    abort = 1'b0;
    cyc(cfg_exp, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = 12'h0;
    cfg_exp = 48'h0;
    de_exp = 1'b0;

    #3 check_outs(48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(48'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_load(48'hFFF_A5A_0F0_001, 0, 1'b0, 1'b0);
    do_load(48'hFFF_A5A_0F0_001, 3, 1'b0, 1'b0);

    // Abort after two accepted words, with a transfer offered in the abort cycle.
    cyc(cfg_exp, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc(cfg_exp, 1'b1, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 12'h111;
    cyc(cfg_exp, 1'b1, 1'b1, 1'b1, 1'b0);
    in_data = 12'h222;
    cyc(cfg_exp, 1'b1, 1'b1, 1'b1, 1'b0);
    in_data = 12'h333;
    abort = 1'b1;
    cyc(cfg_exp, 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    in_valid = 1'b0;
    cyc(cfg_exp, 1'b1, 1'b0, 1'b0, 1'b0);

    do_load(48'h123_456_789_ABC, 0, 1'b1, 1'b0);
    do_load(48'h0F0_F0F_00F_F00, 0, 1'b0, 1'b1);
    do_load(48'h5A5_3C3_C3C_A5A, 1, 1'b0, 1'b0);

    check("sb_pending", 48'(sb.size()), 48'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
